// File: rtl/fwft_sync_fifo_if.sv
// Handshake and status bundle for fwft_sync_fifo.
// The producer/consumer side uses `master`; the FIFO itself uses `slave`.
interface fwft_sync_fifo_if #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 9
);
    logic              clr;
    logic              we;
    logic [DATA_W-1:0] di;
    logic              re;
    logic [DATA_W-1:0] dout;
    logic              valid;
    logic              full_flag;
    logic              empty_flag;
    logic              afull;
    logic              aempty;
    logic [ADDR_W:0]   level;
    logic              ovf;
    logic              udf;

    modport master (
        output clr, we, di, re,
        input  dout, valid, full_flag, empty_flag, afull, aempty, level, ovf, udf
    );

    modport slave (
        input  clr, we, di, re,
        output dout, valid, full_flag, empty_flag, afull, aempty, level, ovf, udf
    );
endinterface

// File: rtl/fwft_sync_fifo.sv
// Single-clock first-word-fall-through FIFO: storage array plus one output register,
// with level/threshold flags, synchronous flush and sticky overflow/underflow errors.
module fwft_sync_fifo #(
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned AFULL_TH  = 2**ADDR_W - 4,
    parameter int unsigned AEMPTY_TH = 4
) (
    input logic             clk,
    input logic             rst,
    fwft_sync_fifo_if.slave bus
);
    localparam int unsigned DEPTH = 2**ADDR_W;

    localparam logic [ADDR_W:0]   DEPTH_LV  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AFULL_LV  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0]   AEMPTY_LV = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              full;
    logic              wr_ok;
    logic              pop;
    logic              ram_rd;
    logic [ADDR_W:0]   level;

    assign full  = (ram_cnt_q == DEPTH_LV);
    assign level = ram_cnt_q + (ADDR_W+1)'(valid_q);

    // clr/rst discard any write that coincides with them.
    assign wr_ok  = bus.we && !full && !bus.clr && !rst;
    assign pop    = bus.re && valid_q;
    // Refill the output register whenever it is empty or being consumed this cycle.
    assign ram_rd = (ram_cnt_q != '0) && (!valid_q || bus.re);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        dout_d    = dout_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q | (bus.we & full);
        udf_d     = udf_q | (bus.re & ~valid_q);

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (ram_rd) begin
            dout_d   = mem[rd_ptr_q];
            valid_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else if (pop) begin
            valid_d = 1'b0;
        end

        if (wr_ok && !ram_rd) begin
            ram_cnt_d = ram_cnt_q + CNT_ONE;
        end else if (!wr_ok && ram_rd) begin
            ram_cnt_d = ram_cnt_q - CNT_ONE;
        end

        // Flush keeps the last head word visible on dout.
        if (bus.clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            ram_cnt_d = '0;
            dout_d    = dout_q;
            valid_d   = 1'b0;
            ovf_d     = 1'b0;
            udf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // Storage array carries no reset so it can map onto block RAM / register files.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= bus.di;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.valid      = valid_q;
    assign bus.full_flag  = full;
    assign bus.empty_flag = ~valid_q;
    assign bus.afull      = (level >= AFULL_LV);
    assign bus.aempty     = (level <= AEMPTY_LV);
    assign bus.level      = level;
    assign bus.ovf        = ovf_q;
    assign bus.udf        = udf_q;
endmodule

// File: tb/tb_fwft_sync_fifo.sv
// Scoreboard bench for fwft_sync_fifo: stimulus queues expected words, a negedge monitor
// checks every consumed head word; flags are checked directly after each step.
module tb_fwft_sync_fifo;
    localparam int unsigned DATA_W = 24;
    localparam int unsigned ADDR_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [DATA_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    fwft_sync_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    fwft_sync_fifo #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .AFULL_TH (14),
        .AEMPTY_TH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a head word is consumed at the next edge when re && valid (and no flush).
    always @(negedge clk) begin
        if (!rst && !bus.clr && bus.re && bus.valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 32'(bus.dout), 32'hdead_beef);
            end else begin
                chk("pop_data", 32'(bus.dout), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        bus.clr = 1'b0;
        bus.we  = 1'b0;
        bus.re  = 1'b0;
        bus.di  = '0;

        // 1: reset and first word
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_dout", 32'(bus.dout), 32'h0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_empty", 32'(bus.empty_flag), 32'd1);
        chk("rst_full", 32'(bus.full_flag), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_aempty", 32'(bus.aempty), 32'd1);
        chk("rst_afull", 32'(bus.afull), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_udf", 32'(bus.udf), 32'd0);

        bus.we = 1'b1;
        bus.di = 24'hA5A5A5;
        exp_q.push_back(24'hA5A5A5);
        tick();
        bus.we = 1'b0;
        chk("t1_e0_valid", 32'(bus.valid), 32'd0);
        chk("t1_e0_level", 32'(bus.level), 32'd1);
        tick();
        chk("t1_e1_valid", 32'(bus.valid), 32'd1);
        chk("t1_e1_dout", 32'(bus.dout), 32'hA5A5A5);
        chk("t1_e1_level", 32'(bus.level), 32'd1);
        chk("t1_e1_empty", 32'(bus.empty_flag), 32'd0);
        bus.re = 1'b1;
        tick();
        bus.re = 1'b0;
        chk("t1_drained", 32'(bus.level), 32'd0);

        // 2: fill past capacity; 17 words fit (16 in array + output register)
        for (int i = 0; i <= 18; i++) begin
            bus.we = 1'b1;
            bus.di = DATA_W'(i);
            if (i <= 16) exp_q.push_back(DATA_W'(i));
            tick();
            chk("t2_level", 32'(bus.level), (i < 16) ? 32'(i + 1) : 32'd17);
            chk("t2_afull", 32'(bus.afull), (i + 1 >= 14) ? 32'd1 : 32'd0);
            chk("t2_aempty", 32'(bus.aempty), (i + 1 <= 2) ? 32'd1 : 32'd0);
            if (i == 16) chk("t2_full_at17", 32'(bus.full_flag), 32'd1);
            if (i == 16) chk("t2_ovf_before", 32'(bus.ovf), 32'd0);
        end
        bus.we = 1'b0;
        chk("t2_ovf", 32'(bus.ovf), 32'd1);
        bus.re = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        bus.re = 1'b0;
        chk("t2_drain_level", 32'(bus.level), 32'd0);
        chk("t2_drain_valid", 32'(bus.valid), 32'd0);
        chk("t2_ovf_sticky", 32'(bus.ovf), 32'd1);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3: streaming with pointer wrap at constant level 3
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("t3_clr_ovf", 32'(bus.ovf), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.we = 1'b1;
            bus.di = DATA_W'(100 + i);
            exp_q.push_back(DATA_W'(100 + i));
            tick();
        end
        chk("t3_fill_level", 32'(bus.level), 32'd3);
        bus.re = 1'b1;
        for (int i = 3; i < 43; i++) begin
            bus.di = DATA_W'(100 + i);
            exp_q.push_back(DATA_W'(100 + i));
            tick();
            chk("t3_level", 32'(bus.level), 32'd3);
        end
        bus.we = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus.re = 1'b0;
        chk("t3_end_level", 32'(bus.level), 32'd0);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4: underflow
        bus.re = 1'b1;
        tick();
        bus.re = 1'b0;
        chk("t4_udf", 32'(bus.udf), 32'd1);
        chk("t4_level", 32'(bus.level), 32'd0);
        chk("t4_valid", 32'(bus.valid), 32'd0);

        // 5: flush at level 9 with a coincident write
        for (int i = 0; i < 9; i++) begin
            bus.we = 1'b1;
            bus.di = DATA_W'(200 + i);
            exp_q.push_back(DATA_W'(200 + i));
            tick();
        end
        chk("t5_level9", 32'(bus.level), 32'd9);
        chk("t5_udf_held", 32'(bus.udf), 32'd1);
        bus.clr = 1'b1;
        bus.di  = 24'h000777;
        tick();
        bus.clr = 1'b0;
        bus.we  = 1'b0;
        exp_q.delete();
        chk("t5_level", 32'(bus.level), 32'd0);
        chk("t5_valid", 32'(bus.valid), 32'd0);
        chk("t5_ovf", 32'(bus.ovf), 32'd0);
        chk("t5_udf", 32'(bus.udf), 32'd0);
        chk("t5_dout_held", 32'(bus.dout), 32'd200);
        bus.we = 1'b1;
        bus.di = 24'h00BEEF;
        exp_q.push_back(24'h00BEEF);
        tick();
        bus.we = 1'b0;
        chk("t5_e0_valid", 32'(bus.valid), 32'd0);
        tick();
        chk("t5_e1_valid", 32'(bus.valid), 32'd1);
        chk("t5_e1_dout", 32'(bus.dout), 32'h00BEEF);

        // 6: write and pop together with an empty array
        bus.we = 1'b1;
        bus.re = 1'b1;
        bus.di = 24'h123456;
        exp_q.push_back(24'h123456);
        tick();
        bus.we = 1'b0;
        bus.re = 1'b0;
        chk("t6_bubble_valid", 32'(bus.valid), 32'd0);
        chk("t6_bubble_level", 32'(bus.level), 32'd1);
        tick();
        chk("t6_valid", 32'(bus.valid), 32'd1);
        chk("t6_dout", 32'(bus.dout), 32'h123456);
        chk("t6_level", 32'(bus.level), 32'd1);
        bus.re = 1'b1;
        tick();
        bus.re = 1'b0;
        chk("t6_end_level", 32'(bus.level), 32'd0);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
